// File: rtl/debounce_pkg.sv
// Shared state encoding and default timing for the button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;   // 5 ms at 50 MHz
  localparam int DEF_CNT_W           = 18;
  localparam int DEF_REPEAT_DELAY    = 25000000; // 500 ms at 50 MHz
  localparam int DEF_REPEAT_PERIOD   = 5000000;  // 100 ms at 50 MHz

endpackage

// File: rtl/stable_counter.sv
// Clearable counter that saturates at a terminal value and flags when it is there.
module stable_counter #(
  parameter int CNT_W = 18
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == term_i);

  // Clear wins over count; holding at the terminal keeps the counter from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a synchronized button into a clean level plus one-cycle press/release pulses.
// Define BUTTON_DEBOUNCER_AUTOREPEAT_EN to add auto-repeat press pulses while held.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic in_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e state_q, state_d;
  logic   level_q, level_d;
  logic   press_q, press_d;
  logic   release_q, release_d;
  logic   cnt_en, cnt_done;
  logic   rep_fire;

  stable_counter #(
    .CNT_W (CNT_W)
  ) u_db_cnt (
    .clk_i  (clock_i),
    .rst_i  (reset_i),
    .clr_i  (!cnt_en),
    .en_i   (cnt_en),
    .term_i (DB_TERM),
    .done_o (cnt_done)
  );

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX + 1) : 1;

  logic             rep_first_q, rep_first_d;
  logic             rep_held, rep_en, rep_clr, rep_done;
  logic [REP_W-1:0] rep_term;

  // RELEASE_WAIT freezes the repeat count so a rejected release bounce resumes the cadence.
  assign rep_held = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
  assign rep_fire = (state_q == ST_PRESSED) && in_i && rep_done;
  assign rep_en   = (state_q == ST_PRESSED) && in_i;
  assign rep_clr  = rep_fire || !rep_held;
  assign rep_term = rep_first_q ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);

  stable_counter #(
    .CNT_W (REP_W)
  ) u_rep_cnt (
    .clk_i  (clock_i),
    .rst_i  (reset_i),
    .clr_i  (rep_clr),
    .en_i   (rep_en),
    .term_i (rep_term),
    .done_o (rep_done)
  );

  always_comb begin
    rep_first_d = rep_first_q;
    if (!rep_held) begin
      rep_first_d = 1'b1;
    end else if (rep_fire) begin
      rep_first_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rep_first_q <= 1'b1;
    end else begin
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_i) state_d = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!in_i) begin
          state_d = ST_IDLE;
        end else if (cnt_done) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!in_i) begin
          state_d = ST_RELEASE_WAIT;
        end else begin
          press_d = rep_fire;
        end
      end
      ST_RELEASE_WAIT: begin
        if (in_i) begin
          state_d = ST_PRESSED;
        end else if (cnt_done) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES = 4.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic in_sig;
  logic level, press, rel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
`endif
  ) dut (
    .clock_i   (clk),
    .reset_i   (rst),
    .in_i      (in_sig),
    .level_o   (level),
    .press_o   (press),
    .release_o (rel)
  );

  typedef struct {
    logic       rst;
    logic       in;
    logic [2:0] exp;   // {level, press, release} after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic i, input logic [2:0] e);
    vec_t v;
    v.rst = r;
    v.in  = i;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step_check(input string name, input int idx,
                            input logic r, input logic i, input logic [2:0] e);
    logic [2:0] got;
    @(negedge clk);
    rst    = r;
    in_sig = i;
    @(posedge clk);
    #1;
    got = {level, press, rel};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s[%0d]: {level,press,release} got %b expected %b", name, idx, got, e);
    end
  endtask

  initial begin
    rst    = 1'b1;
    in_sig = 1'b1;

    // Reset held with in=1, then five high samples to press.
    repeat (3) add(1, 1, 3'b000);
    repeat (4) add(0, 1, 3'b000);
    add(0, 1, 3'b110);
    repeat (3) add(0, 1, 3'b100);
    // Release bounce of 3 low samples, then a clean release.
    repeat (3) add(0, 0, 3'b100);
    add(0, 1, 3'b100);
    repeat (4) add(0, 0, 3'b100);
    add(0, 0, 3'b001);
    add(0, 0, 3'b000);
    // Press bounce 1,1,1,0,1,1,1,1,1.
    repeat (3) add(0, 1, 3'b000);
    add(0, 0, 3'b000);
    repeat (4) add(0, 1, 3'b000);
    add(0, 1, 3'b110);
    add(0, 1, 3'b100);
    repeat (4) add(0, 0, 3'b100);
    add(0, 0, 3'b001);
    add(0, 0, 3'b000);
    // Reset at cnt=2 in PRESS_WAIT, then a full press and release.
    repeat (3) add(0, 1, 3'b000);
    add(1, 1, 3'b000);
    repeat (4) add(0, 1, 3'b000);
    add(0, 1, 3'b110);
    repeat (4) add(0, 0, 3'b100);
    add(0, 0, 3'b001);

    foreach (vecs[k]) step_check("vec", k, vecs[k].rst, vecs[k].in, vecs[k].exp);

    // Long hold: single press at sample 4, plus repeats at 14, 17, ... when enabled.
    for (int i = 0; i < 30; i++) begin
      logic [2:0] e;
      logic       p;
      p = (i == 4);
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
      if (i >= 14 && ((i - 14) % 3) == 0) p = 1'b1;
`endif
      e = {(i >= 4), p, 1'b0};
      step_check("hold", i, 1'b0, 1'b1, e);
    end

    // Reset while PRESSED discards the event: no release pulse afterwards.
    step_check("rst_pressed", 0, 1'b1, 1'b1, 3'b000);
    for (int i = 0; i < 6; i++) step_check("after_rst", i, 1'b0, 1'b0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
